// File: rtl/peak_note_classifier.sv
// Classifies one FFT peak per frame into a note band (sequential boundary search),
// gates silence by magnitude, and debounces across frames before updating the note output.
module peak_note_classifier #(
  parameter int                              NSamples      = 256,
  parameter int                              W             = 33,
  parameter int                              NBits         = $clog2(NSamples),
  parameter int                              NUM_NOTES     = 8,
  parameter int                              NOTE_BITS     = $clog2(NUM_NOTES),
  parameter logic [(NUM_NOTES+1)*NBits-1:0]  BOUNDS        = {8'd28, 8'd24, 8'd21, 8'd19, 8'd16,
                                                              8'd14, 8'd12, 8'd10, 8'd8},
  parameter int unsigned                     MAG_THRESH    = 4096,
  parameter int                              STABLE_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         peak,
  input  logic [NBits-1:0]     peak_k,
  input  logic                 peak_valid,
  output logic [NOTE_BITS-1:0] note,
  output logic                 note_present,
  output logic                 note_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW     = $clog2(STABLE_FRAMES + 1);
  localparam int CAND_W = NOTE_BITS + 1;
  // Candidate MSB set means NONE; the current output uses the same encoding.
  localparam logic [CAND_W-1:0] CAND_NONE = {1'b1, {NOTE_BITS{1'b0}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(STABLE_FRAMES)) return CW'(STABLE_FRAMES);
    return c + 1'b1;
  endfunction

  function automatic logic [NBits-1:0] bound_at(input int idx);
    return BOUNDS[idx*NBits +: NBits];
  endfunction

  logic [1:0]           state_q, state_d;
  logic [NBits-1:0]     k_q, k_d;
  logic [NOTE_BITS-1:0] j_q, j_d;
  logic [CAND_W-1:0]    cand_q, cand_d;
  logic [CAND_W-1:0]    last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic                 present_q, present_d;
  logic                 nvalid_q, nvalid_d;
  logic                 ovr_q, ovr_d;
  logic [NBits-1:0]     bnd_lo, bnd_hi;
  logic [CW-1:0]        cnt_new;

  assign bnd_lo = bound_at(int'(j_q));
  assign bnd_hi = bound_at(int'(j_q) + 1);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    j_d       = j_q;
    cand_d    = cand_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    note_d    = note_q;
    present_d = present_q;
    nvalid_d  = 1'b0;
    ovr_d     = ovr_q;
    cnt_new   = cnt_q;

    if (peak_valid && (state_q != IDLE)) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (peak_valid) begin
          k_d = peak_k;
          j_d = '0;
          if (peak < W'(MAG_THRESH)) begin
            cand_d  = CAND_NONE;
            state_d = DECIDE;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if ((k_q >= bnd_lo) && (k_q < bnd_hi)) begin
          cand_d  = {1'b0, j_q};
          state_d = DECIDE;
        end else if (j_q == NOTE_BITS'(NUM_NOTES - 1)) begin
          cand_d  = CAND_NONE;
          state_d = DECIDE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DECIDE: begin
        cnt_new = (cand_q == last_q) ? sat_inc(cnt_q) : CW'(1);
        last_d  = cand_q;
        cnt_d   = cnt_new;
        if ((cnt_new == CW'(STABLE_FRAMES)) && (cand_q != {~present_q, note_q})) begin
          note_d    = cand_q[NOTE_BITS] ? '0 : cand_q[NOTE_BITS-1:0];
          present_d = ~cand_q[NOTE_BITS];
          nvalid_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= CAND_NONE;
      cnt_q     <= '0;
      note_q    <= '0;
      present_q <= 1'b0;
      nvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      present_q <= present_d;
      nvalid_q  <= nvalid_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame data: always rewritten before it is consumed, so no reset needed.
  always_ff @(posedge clk) begin
    k_q    <= k_d;
    j_q    <= j_d;
    cand_q <= cand_d;
  end

  assign note         = note_q;
  assign note_present = present_q;
  assign note_valid   = nvalid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_peak_note_classifier.sv
// Self-checking bench for peak_note_classifier: directed vector table, hand-written
// overrun/reset sequences, then random frames against a behavioural model.
module tb_peak_note_classifier;

  localparam int WIN = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] peak;
  logic [7:0]  peak_k;
  logic        peak_valid;
  logic [2:0]  note;
  logic        note_present;
  logic        note_valid;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  peak_note_classifier dut (
    .clk          (clk),
    .reset        (reset),
    .peak         (peak),
    .peak_k       (peak_k),
    .peak_valid   (peak_valid),
    .note         (note),
    .note_present (note_present),
    .note_valid   (note_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] p;
    logic [7:0]  k;
    int          pulse;
    int          note;
    bit          pres;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [32:0] p, input logic [7:0] k, input int pulse,
                              input int nt, input bit pres);
    vec_t v;
    v = '{p, k, pulse, nt, pres};
    vecs.push_back(v);
  endfunction

  // One frame: strobe in cycle 0, observe a fixed window, compare pulse timing and outputs.
  task automatic run_frame(input logic [32:0] p, input logic [7:0] k, input bit inject,
                           input int exp_pulse, input int exp_note, input bit exp_pres,
                           input string tag);
    int first;
    int npulse;
    first  = -1;
    npulse = 0;
    @(negedge clk);
    peak = p; peak_k = k; peak_valid = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (inject) begin peak = 33'd10000; peak_k = 8'd8; end
        else peak_valid = 1'b0;
        check({tag, " busy_c1"}, busy, 1);
      end
      if (c == 2) peak_valid = 1'b0;
      if (note_valid) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    check({tag, " pulse_cycle"}, first, exp_pulse);
    check({tag, " pulse_count"}, npulse, (exp_pulse < 0) ? 0 : 1);
    check({tag, " note"}, note, exp_note);
    check({tag, " note_present"}, note_present, exp_pres);
    check({tag, " busy_end"}, busy, 0);
  endtask

  // Behavioural model
  int bnds[9] = '{8, 10, 12, 14, 16, 19, 21, 24, 28};
  int hist[$];
  int cur = -1;

  function automatic int classify(input logic [32:0] p, input int k);
    if (p < 33'd4096) return -1;
    for (int b = 0; b < 8; b++)
      if (k >= bnds[b] && k < bnds[b+1]) return b;
    return -1;
  endfunction

  function automatic int latency(input logic [32:0] p, input int k);
    int c;
    if (p < 33'd4096) return 2;
    c = classify(p, k);
    return (c >= 0) ? c + 3 : 10;
  endfunction

  initial begin
    int first;
    int npulse;
    int prev_k;
    reset = 1'b1; peak = '0; peak_k = '0; peak_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset note", note, 0);
    check("reset note_present", note_present, 0);
    check("reset note_valid", note_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    @(negedge clk) reset = 1'b0;

    add(33'd10000, 12, -1, 0, 0); add(33'd10000, 12, -1, 0, 0); add(33'd10000, 12, 5, 2, 1);
    add(33'd10000, 12, -1, 2, 1); add(33'd10000, 12, -1, 2, 1);
    add(33'd100, 12, -1, 2, 1);   add(33'd100, 12, -1, 2, 1);   add(33'd100, 12, 2, 0, 0);
    add(33'd10000, 8, -1, 0, 0);  add(33'd10000, 8, -1, 0, 0);  add(33'd10000, 8, 3, 0, 1);
    add(33'd10000, 27, -1, 0, 1); add(33'd10000, 27, -1, 0, 1); add(33'd10000, 27, 10, 7, 1);
    add(33'd10000, 28, -1, 7, 1); add(33'd10000, 28, -1, 7, 1); add(33'd10000, 28, 10, 0, 0);
    add(33'd10000, 7, -1, 0, 0);  add(33'd10000, 7, -1, 0, 0);  add(33'd10000, 7, -1, 0, 0);
    add(33'd4096, 16, -1, 0, 0);  add(33'd4096, 16, -1, 0, 0);  add(33'd4096, 16, 7, 4, 1);
    add(33'd100, 12, -1, 4, 1);   add(33'd100, 12, -1, 4, 1);   add(33'd100, 12, 2, 0, 0);
    for (int i = 0; i < 10; i++) add(33'd10000, (i % 2 == 0) ? 8'd12 : 8'd16, -1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].p, vecs[i].k, 1'b0, vecs[i].pulse, vecs[i].note, vecs[i].pres,
                $sformatf("vec%0d", i));
      if (i == 0) repeat (300) @(posedge clk);
    end

    // Overrun: second strobe while searching is ignored, first frame completes.
    run_frame(33'd10000, 27, 1'b0, -1, 0, 0, "ovr_pre1");
    run_frame(33'd10000, 27, 1'b0, -1, 0, 0, "ovr_pre2");
    check("overrun before", overrun, 0);
    run_frame(33'd10000, 27, 1'b1, 10, 7, 1, "ovr_hit");
    check("overrun set", overrun, 1);
    repeat (5) @(posedge clk);
    #1 check("overrun sticky", overrun, 1);

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    peak = 33'd10000; peak_k = 8'd27; peak_valid = 1'b1;
    @(posedge clk); #1 peak_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_mid busy_before", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid note", note, 0);
    check("rst_mid note_present", note_present, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid overrun", overrun, 0);
    @(negedge clk) reset = 1'b0;
    npulse = 0;
    for (int c = 0; c < WIN; c++) begin
      @(posedge clk); #1;
      if (note_valid) npulse++;
    end
    check("rst_mid no_pulse", npulse, 0);
    check("rst_mid busy_after", busy, 0);

    // Random frames against the model (state was just reset).
    hist.delete();
    cur = -1;
    prev_k = 12;
    for (int f = 0; f < 60; f++) begin
      logic [32:0] p;
      int k, cand, lat, exp_pulse;
      case ($urandom_range(3, 0))
        0: p = 33'($urandom_range(4095, 0));
        1: p = 33'd4096;
        2: p = 33'd4095;
        default: p = {1'($urandom_range(1, 0)), 32'($urandom)} | 33'd4096;
      endcase
      if ($urandom_range(9, 0) < 6) k = prev_k;
      else k = $urandom_range(35, 0);
      prev_k = k;
      cand = classify(p, k);
      lat  = latency(p, k);
      hist.push_back(cand);
      if (hist.size() > 3) void'(hist.pop_front());
      exp_pulse = -1;
      if (hist.size() == 3 && hist[0] == hist[1] && hist[1] == hist[2] && hist[0] != cur) begin
        cur = cand;
        exp_pulse = lat;
      end
      run_frame(p, 8'(k), 1'b0, exp_pulse, (cur < 0) ? 0 : cur, cur >= 0,
                $sformatf("rnd%0d", f));
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
    check("rnd overrun clear", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
